rw_port_arbiter: RTL and testbench
==================================

# rw_port_arbiter

Arbiter and sequencer that shares port A of the `RW_registers` dual-port register memory between two requesters: requester 0 is the pipeline memory stage and requester 1 is the external loader/debug path. It issues at most one access per cycle and tracks in-flight reads through the memory's fixed read latency. It returns read data only to the requester that issued the read. Port B of the memory is not touched by this block.

## Interface
- `ADDR_W`, 16, memory address width
- `DATA_W`, 12, memory data width
- `RD_LAT`, 2, cycles from the grant edge to valid `mem_q_a`; legal range 1..4
- `MAX_WAIT`, 4, consecutive lost cycles before requester 1 is promoted (used only with the guard macro)

Ports:
- `inclock` in 1 — single clock; all state updates on the rising edge
- `reset` in 1 — synchronous, active-high
- `rN_req` in 1 (N=0,1) — access request; held stable until granted
- `rN_we` in 1 — 1 = write, 0 = read
- `rN_addr` in ADDR_W — access address
- `rN_wdata` in DATA_W — write data
- `rN_gnt` out 1 — combinational; the access transfers on an edge where `rN_req && rN_gnt`
- `rN_rvalid` out 1 — one-cycle pulse; `rN_rdata` is valid
- `rN_rdata` out DATA_W — registered read data; holds its value between pulses
- `mem_address_a` out ADDR_W, `mem_data_a` out DATA_W, `mem_wren_a` out 1, `mem_rden_a` out 1 — drive `RW_registers` port A
- `mem_q_a` in DATA_W — port A read data
- `busy` out 1 — at least one read is in flight

## Operation
- Priority decision is combinational. Base rule: requester 0 wins.
- When both request, requester 1 gets `gnt` only if promoted (see Configuration). At most one `gnt` is high per cycle.
- Memory drive is a combinational mux of the winner:
  - `mem_address_a`/`mem_data_a` = winner's `addr`/`wdata`
  - `mem_wren_a` = grant && we
  - `mem_rden_a` = grant && !we
- With no grant, all `mem_*` outputs are 0.
- Read tracking uses an RD_LAT-deep shift pipeline of {valid, id}. A read grant enters {1, N}; an idle cycle or a write enters {0, x}.
- When the pipeline tail is valid, `mem_q_a` is captured into the owner's `rdata`. On the next cycle the owner's `rvalid` pulses.
- Accesses are fully pipelined. A new grant can occur every cycle, so back-to-back reads from mixed requesters return in issue order.
- Writes produce no response. A read issued the cycle after a write to the same address returns the new data; the memory guarantees this, and the arbiter adds no forwarding.
- `busy` = OR of the pipeline valid bits, plus a pending `rvalid` stage.

## Timing
- Reset values:
  - every `gnt`, `rvalid` and `busy` is 0
  - `rdata` = 0
  - pipeline valids = 0
  - wait counter = 0
- During reset, `gnt` is forced to 0, so no memory access issues.
- Read latency: grant on edge T; `rvalid` is high during cycle T+RD_LAT+1. With the default, that is 3 cycles after the grant edge.
- Reset asserted mid-operation flushes all in-flight reads. No `rvalid` appears for them after reset is released.
- Simultaneous request from both with no promotion: `r0_gnt`=1, `r1_gnt`=0. Requester 1 keeps holding its request.
- A requester that deasserts `req` before its grant is allowed. Nothing is issued for it and the wait counter clears.
- Arbitration is unaffected by in-flight reads; there is no stall condition.

## Configuration
- Macro `RW_ARB_STARVE_GUARD_EN`.
- Defined: a saturating wait counter (width clog2(MAX_WAIT)+1) behaves as follows:
  - increments each cycle with `r1_req && !r1_gnt`
  - clears on an `r1_gnt` or when `r1_req` is low
  - when the counter equals MAX_WAIT, requester 1 wins the next contended cycle
- Undefined: strict priority to requester 0. The counter logic is absent, and requester 1 can starve indefinitely.

## Test plan
- Reset, then no requests:
  - all outputs 0
  - `mem_wren_a`=`mem_rden_a`=0 for 10 cycles
- r0 writes 0x00F to addr 0x0000, then r1 reads addr 0x0000:
  - r1 `gnt` the cycle after the write
  - `r1_rvalid` pulses 3 cycles after its grant with `r1_rdata`=0x00F
  - `r0_rvalid` never pulses
- Back-to-back reads on consecutive cycles, addr 0x0001 from r0 then 0x0002 from r1 (memory preloaded 0x111/0x222):
  - `r0_rvalid` carries 0x111 in cycle T+3
  - `r1_rvalid` carries 0x222 in cycle T+4
- Both request continuously:
  - guard undefined: r1 never granted over 20 cycles
  - guard defined (MAX_WAIT=4): r1 granted on the 5th contended cycle, then the counter returns to 0
- Reset asserted one cycle after a read grant:
  - no `rvalid` is ever produced for that read
  - `busy`=0 the cycle after reset
- r1 raises `req` for 2 cycles while r0 holds priority, then drops it:
  - no r1 access reaches port A
  - the wait counter reads 0 afterwards

Source files
------------

// File: rtl/rw_port_arbiter_if.sv
// rtl/rw_port_arbiter_if.sv - signal bundle between rw_port_arbiter, its two requesters and memory port A
//
// Signals:
//   rN_req/rN_we/rN_addr/rN_wdata : access request from requester N (0 = pipeline, 1 = loader/debug)
//   rN_gnt                        : combinational grant; access transfers on an edge with req && gnt
//   rN_rvalid/rN_rdata            : one-cycle read response pulse and registered read data
//   mem_address_a/mem_data_a/mem_wren_a/mem_rden_a : RW_registers port A drive
//   mem_q_a                       : RW_registers port A read data
//   busy                          : at least one read in flight
// Modports: slave = arbiter side, master = requester/memory side.
interface rw_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 12
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic [ADDR_W-1:0] mem_address_a;
    logic [DATA_W-1:0] mem_data_a;
    logic              mem_wren_a;
    logic              mem_rden_a;
    logic [DATA_W-1:0] mem_q_a;

    logic              busy;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_q_a,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_address_a, mem_data_a, mem_wren_a, mem_rden_a,
        output busy
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_q_a,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_address_a, mem_data_a, mem_wren_a, mem_rden_a,
        input  busy
    );
endinterface

// File: rtl/rw_port_arbiter.sv
// rtl/rw_port_arbiter.sv - two-requester arbiter/sequencer for RW_registers port A
//
// Ports:
//   inclock : clock, all state on the rising edge
//   reset   : synchronous, active-high; forces grants low and flushes in-flight reads
//   bus     : rw_port_arbiter_if.slave (requester handshakes, port A drive, busy)
// Optional feature: define RW_ARB_STARVE_GUARD_EN to add the requester-1 wait
// counter that promotes requester 1 after MAX_WAIT consecutive lost cycles.
module rw_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 12,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic             inclock,
    input  logic             reset,
    rw_port_arbiter_if.slave bus
);

    if (RD_LAT < 1 || RD_LAT > 4 || MAX_WAIT < 1) begin : g_bad_param
        $error("rw_port_arbiter: RD_LAT must be 1..4 and MAX_WAIT at least 1");
    end

    logic gnt0;
    logic gnt1;
    logic promote;

`ifdef RW_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_WAIT) + 1;

    logic [CNT_W-1:0] wait_cnt;

    assign promote = (wait_cnt == CNT_W'(MAX_WAIT));

    // Counts consecutive cycles requester 1 waits; saturates at MAX_WAIT
    // (it cannot lose while promoted, but the cap keeps it from wrapping).
    always_ff @(posedge inclock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!bus.r1_req || gnt1) begin
            wait_cnt <= '0;
        end else if (!promote) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign promote = 1'b0;
`endif

    // Requester 0 wins unless requester 1 has been promoted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (bus.r1_req && (!bus.r0_req || promote)) begin
                gnt1 = 1'b1;
            end else if (bus.r0_req) begin
                gnt0 = 1'b1;
            end
        end
    end

    assign bus.r0_gnt = gnt0;
    assign bus.r1_gnt = gnt1;

    always_comb begin
        bus.mem_address_a = '0;
        bus.mem_data_a    = '0;
        bus.mem_wren_a    = 1'b0;
        bus.mem_rden_a    = 1'b0;
        if (gnt0) begin
            bus.mem_address_a = bus.r0_addr;
            bus.mem_data_a    = bus.r0_wdata;
            bus.mem_wren_a    = bus.r0_we;
            bus.mem_rden_a    = !bus.r0_we;
        end else if (gnt1) begin
            bus.mem_address_a = bus.r1_addr;
            bus.mem_data_a    = bus.r1_wdata;
            bus.mem_wren_a    = bus.r1_we;
            bus.mem_rden_a    = !bus.r1_we;
        end
    end

    // pipe_v/pipe_id shift left each cycle; bit 0 takes the access issued on
    // this edge, bit RD_LAT-1 is the read whose data sits on mem_q_a now.
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_id;

    // Pending stage holds the captured word for one cycle so that the owner's
    // rdata only changes together with its rvalid pulse.
    logic              pend_v;
    logic              pend_id;
    logic [DATA_W-1:0] pend_data;

    always_ff @(posedge inclock) begin
        if (reset) begin
            pipe_v        <= '0;
            pipe_id       <= '0;
            pend_v        <= 1'b0;
            pend_id       <= 1'b0;
            pend_data     <= '0;
            bus.r0_rvalid <= 1'b0;
            bus.r1_rvalid <= 1'b0;
            bus.r0_rdata  <= '0;
            bus.r1_rdata  <= '0;
        end else begin
            pipe_v  <= (pipe_v << 1) | RD_LAT'(bus.mem_rden_a);
            pipe_id <= (pipe_id << 1) | RD_LAT'(gnt1);

            pend_v  <= pipe_v[RD_LAT-1];
            pend_id <= pipe_id[RD_LAT-1];
            if (pipe_v[RD_LAT-1]) begin
                pend_data <= bus.mem_q_a;
            end

            bus.r0_rvalid <= pend_v && !pend_id;
            bus.r1_rvalid <= pend_v && pend_id;
            if (pend_v && !pend_id) begin
                bus.r0_rdata <= pend_data;
            end
            if (pend_v && pend_id) begin
                bus.r1_rdata <= pend_data;
            end
        end
    end

    assign bus.busy = (|pipe_v) || pend_v;

endmodule

// File: tb/tb_rw_port_arbiter.sv
// tb/tb_rw_port_arbiter.sv - directed self-checking bench for rw_port_arbiter
module tb_rw_port_arbiter;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 12;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    rw_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rw_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .inclock(clk),
        .reset  (rst),
        .bus    (bus)
    );

    // Port A memory model: write on the edge, read data for the address
    // issued on edge T is presented so it is sampled on edge T+RD_LAT.
    logic [DATA_W-1:0] mem [0:255];
    logic [7:0]        mpipe0;
    logic [7:0]        mpipe1;

    always @(posedge clk) begin
        if (bus.mem_wren_a) mem[bus.mem_address_a[7:0]] <= bus.mem_data_a;
        mpipe0 <= bus.mem_address_a[7:0];
        mpipe1 <= mpipe0;
    end

    assign bus.mem_q_a = mem[mpipe1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
    endtask

    task automatic req0(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    endtask

    task automatic req1(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    endtask

    initial begin
        idle();
        // Request during reset must not be granted.
        req0(1'b0, 16'h0009, 12'h000);
        step();
        step();
        #1;
        check("gnt0_in_reset", 32'(bus.r0_gnt), 32'd0);
        check("rden_in_reset", 32'(bus.mem_rden_a), 32'd0);
        idle();
        rst = 1'b0;
        #1;
        check("reset_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
        check("reset_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
        check("reset_r0_rdata", 32'(bus.r0_rdata), 32'd0);
        check("reset_r1_rdata", 32'(bus.r1_rdata), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_gnts", 32'({bus.r0_gnt, bus.r1_gnt}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_wren_rden", 32'({bus.mem_wren_a, bus.mem_rden_a}), 32'd0);
        end

        // r0 writes 0x00F to 0, then r1 reads 0.
        req0(1'b1, 16'h0000, 12'h00F);
        #1;
        check("wr_gnt0", 32'(bus.r0_gnt), 32'd1);
        check("wr_wren", 32'(bus.mem_wren_a), 32'd1);
        check("wr_data", 32'(bus.mem_data_a), 32'h00F);
        step();
        idle();
        req1(1'b0, 16'h0000, 12'h000);
        #1;
        check("rd_gnt1", 32'(bus.r1_gnt), 32'd1);
        check("rd_rden", 32'(bus.mem_rden_a), 32'd1);
        check("rd_addr", 32'(bus.mem_address_a), 32'h0000);
        step();
        idle();
        check("rd_busy", 32'(bus.busy), 32'd1);
        step();
        check("rd_t1_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
        step();
        check("rd_t2_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
        step();
        check("rd_t3_r1_rvalid", 32'(bus.r1_rvalid), 32'd1);
        check("rd_t3_r1_rdata", 32'(bus.r1_rdata), 32'h00F);
        check("rd_t3_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
        check("rd_t3_busy", 32'(bus.busy), 32'd0);
        step();
        check("rd_t4_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
        check("rd_t4_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);

        // Preload 0x111 / 0x222, then back-to-back reads r0 then r1.
        req0(1'b1, 16'h0001, 12'h111);
        step();
        req0(1'b1, 16'h0002, 12'h222);
        step();
        req0(1'b0, 16'h0001, 12'h000);
        #1;
        check("b2b_gnt0", 32'(bus.r0_gnt), 32'd1);
        step();
        idle();
        req1(1'b0, 16'h0002, 12'h000);
        #1;
        check("b2b_gnt1", 32'(bus.r1_gnt), 32'd1);
        step();
        idle();
        step();
        check("b2b_t2_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
        step();
        check("b2b_t3_r0_rvalid", 32'(bus.r0_rvalid), 32'd1);
        check("b2b_t3_r0_rdata", 32'(bus.r0_rdata), 32'h111);
        check("b2b_t3_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
        step();
        check("b2b_t4_r1_rvalid", 32'(bus.r1_rvalid), 32'd1);
        check("b2b_t4_r1_rdata", 32'(bus.r1_rdata), 32'h222);
        check("b2b_t4_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
        step();
        check("b2b_t5_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);

        // Continuous contention.
        req0(1'b0, 16'h0003, 12'h000);
        req1(1'b0, 16'h0004, 12'h000);
        #1;
        for (int k = 0; k < 20; k++) begin
`ifdef RW_ARB_STARVE_GUARD_EN
            check("cont_r1_gnt", 32'(bus.r1_gnt), 32'(k % 5 == 4));
            check("cont_r0_gnt", 32'(bus.r0_gnt), 32'(k % 5 != 4));
            if (k % 5 == 0 && k > 0) check("cont_wait_cnt", 32'(dut.wait_cnt), 32'd0);
`else
            check("cont_r1_gnt", 32'(bus.r1_gnt), 32'd0);
            check("cont_r0_gnt", 32'(bus.r0_gnt), 32'd1);
`endif
            step();
        end
        idle();
        for (int i = 0; i < 6; i++) step();
        check("cont_drain_busy", 32'(bus.busy), 32'd0);

        // Reset one cycle after a read grant flushes the read.
        req0(1'b0, 16'h0001, 12'h000);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("flush_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
            check("flush_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);
            step();
        end

        // r1 requests for two cycles behind r0 and then withdraws.
        req0(1'b1, 16'h0005, 12'h055);
        req1(1'b0, 16'h0007, 12'h000);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("wd_r1_gnt", 32'(bus.r1_gnt), 32'd0);
            check("wd_addr", 32'(bus.mem_address_a), 32'h0005);
            check("wd_wren_rden", 32'({bus.mem_wren_a, bus.mem_rden_a}), 32'b10);
            step();
        end
        idle();
        #1;
        check("wd_idle_r1_gnt", 32'(bus.r1_gnt), 32'd0);
        check("wd_idle_rden", 32'(bus.mem_rden_a), 32'd0);
        step();
`ifdef RW_ARB_STARVE_GUARD_EN
        check("wd_wait_cnt", 32'(dut.wait_cnt), 32'd0);
`endif
        req0(1'b0, 16'h0005, 12'h000);
        step();
        idle();
        step();
        step();
        step();
        check("wd_r0_rvalid", 32'(bus.r0_rvalid), 32'd1);
        check("wd_r0_rdata", 32'(bus.r0_rdata), 32'h055);
        check("wd_r1_rvalid", 32'(bus.r1_rvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
